// File: rtl/wireout_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wireout_rr_arbiter
// Purpose  : Shares one host-visible 16-bit Wire Out word between N_REQ
//            fabric requesters on the ti_clk domain. A round-robin arbiter
//            picks a winner. The winner's payload is latched and tagged with
//            its source ID and a toggling sequence bit. The word is then held
//            stable for HOLD_CYCLES, so host polling always reads a coherent
//            value.
//
// Ports    : ti_clk    in   host interface clock, rising edge
//            rst_n     in   asynchronous active-low reset (sync release)
//            req       in   [N_REQ]        per-requester level request
//            req_data  in   [N_REQ*DATA_W] payloads, requester i at
//                                          [i*DATA_W +: DATA_W]
//            freeze    in   host hold-off; blocks new grants only
//            ack       out  [N_REQ] one-cycle grant acknowledge (one-hot/0)
//            wo_data   out  [16] {seq, id[1:0], payload[12:0]}
//            busy      out  high whenever the FSM is not IDLE
//            wo_stat   out  [16] grant statistics word
//
// Options  : `define WOARB_GRANT_CNT_EN to make wo_stat a saturating grant
//            counter, cleared when freeze rises. When the macro is not
//            defined, wo_stat is tied to zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module wireout_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 13,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                    ti_clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    freeze,
  output logic [N_REQ-1:0]        ack,
  output logic [15:0]             wo_data,
  output logic                    busy,
  output logic [15:0]             wo_stat
);

  localparam int ID_W = 2;

  // A zero hold length is treated as a one-cycle hold.
  localparam int         HOLD_EFF    = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [7:0] C_HOLD_LOAD = 8'(HOLD_EFF - 1);
  localparam logic [ID_W-1:0] C_LAST_RST = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   win_q, win_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       wo_data_q, wo_data_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;

  // Round-robin pick
  logic [ID_W-1:0]   pick;
  logic              pick_valid;
  logic [ID_W-1:0]   scan_idx;
  logic [DATA_W-1:0] sel_payload;

  // Scan upward from the requester after the last winner. N_REQ equals
  // 2**ID_W, so ID_W-bit addition already gives the mod-N_REQ wrap.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = last_q + ID_W'(k);
      if (!pick_valid && req[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  // The payload is taken from the registered winner during GRANT. A request
  // withdrawn in that cycle still completes its transfer.
  assign sel_payload = req_data[win_q*DATA_W +: DATA_W];

  // FSM next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    wo_data_d = wo_data_q;
    ack_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Requests pending under freeze remain visible on req. They win
        // on the first cycle after freeze drops.
        if (!freeze && pick_valid) begin
          win_d   = pick;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // The sequence bit toggles on every update. This lets the host tell
        // two identical back-to-back words apart.
        wo_data_d     = {~wo_data_q[15], win_q, sel_payload};
        ack_d[win_q]  = 1'b1;
        last_d        = win_q;
        cnt_d         = C_HOLD_LOAD;
        state_d       = ST_HOLD;
      end

      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= C_LAST_RST;
      win_q     <= '0;
      cnt_q     <= 8'd0;
      wo_data_q <= 16'h0000;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      wo_data_q <= wo_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign wo_data = wo_data_q;
  assign busy    = busy_q;

  // Optional grant statistics
`ifdef WOARB_GRANT_CNT_EN
  logic        freeze_q, freeze_d;
  logic [15:0] stat_q, stat_d;

  // A rising edge of freeze marks the start of a host multi-word read. It
  // restarts the count. The clear takes priority over a grant in the same
  // cycle.
  always_comb begin
    freeze_d = freeze;
    stat_d   = stat_q;
    if (freeze && !freeze_q) begin
      stat_d = 16'h0000;
    end else if ((state_q == ST_GRANT) && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_q <= 1'b0;
      stat_q   <= 16'h0000;
    end else begin
      freeze_q <= freeze_d;
      stat_q   <= stat_d;
    end
  end

  assign wo_stat = stat_q;
`else
  assign wo_stat = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wireout_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wireout_rr_arbiter
// Purpose  : Self-checking bench for wireout_rr_arbiter. Expected
//            {ack, wo_data} pairs are queued as stimulus is driven and
//            popped when an ack appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wireout_rr_arbiter;

  localparam int N_REQ       = 4;
  localparam int DATA_W      = 13;
  localparam int HOLD_CYCLES = 8;

  logic                    ti_clk = 1'b0;
  logic                    rst_n  = 1'b0;
  logic [N_REQ-1:0]        req    = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic                    freeze = 1'b0;
  logic [N_REQ-1:0]        ack;
  logic [15:0]             wo_data;
  logic                    busy;
  logic [15:0]             wo_stat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] w;
  } exp_t;

  exp_t sb_q[$];
  logic seq_model = 1'b0;

  always #5 ti_clk = ~ti_clk;

  wireout_rr_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_W     (DATA_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .ti_clk  (ti_clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_data(req_data),
    .freeze  (freeze),
    .ack     (ack),
    .wo_data (wo_data),
    .busy    (busy),
    .wo_stat (wo_stat)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_payload(input int id, input logic [DATA_W-1:0] v);
    req_data[id*DATA_W +: DATA_W] = v;
  endtask

  // Model of one update: the sequence bit toggles, then the tagged word is formed.
  task automatic push_exp(input logic [1:0] id, input logic [DATA_W-1:0] pl);
    exp_t e;
    seq_model = ~seq_model;
    e.a = 4'b0001 << id;
    e.w = {seq_model, id, pl};
    sb_q.push_back(e);
  endtask

  // Waits up to budget falling edges for a non-zero ack. cyc=0 means timeout.
  task automatic wait_grant(input int budget, output int cyc,
                            output logic [3:0] a, output logic [15:0] d);
    cyc = 0;
    a   = '0;
    d   = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge ti_clk);
      if (ack !== 4'b0000) begin
        cyc = i;
        a   = ack;
        d   = wo_data;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge ti_clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge ti_clk);
    rst_n = 1'b1;
    seq_model = 1'b0;
    sb_q.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge ti_clk);
  endtask

  task automatic test_reset();
    @(negedge ti_clk);
    n_checks++;
    if ({ack, wo_data, busy, wo_stat} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%h wo_data=%h busy=%b wo_stat=%h, want all 0",
               ack, wo_data, busy, wo_stat);
    end
    rst_n = 1'b1;
    @(negedge ti_clk);
    n_checks++;
    if ({ack, wo_data, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_release: ack=%h wo_data=%h busy=%b, want 0", ack, wo_data, busy);
    end
  endtask

  task automatic test_single();
    int   first_ack = 0;
    int   ack_cnt   = 0;
    int   busy_cnt  = 0;
    exp_t e;
    set_payload(2, 13'h0ABC);
    req = 4'b0100;
    push_exp(2'd2, 13'h0ABC);
    for (int i = 1; i <= 14; i++) begin
      @(negedge ti_clk);
      if (busy === 1'b1) busy_cnt++;
      if (ack !== 4'b0000) begin
        ack_cnt++;
        if (first_ack == 0) begin
          first_ack = i;
          req = 4'b0000;
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_sb: unexpected ack=%h", ack);
          end else begin
            e = sb_q.pop_front();
            if ({ack, wo_data} !== {e.a, e.w}) begin
              n_fail++;
              $display("FAIL single_word: ack=%h wo_data=%h, want ack=%h wo_data=%h",
                       ack, wo_data, e.a, e.w);
            end
          end
        end
      end
    end
    n_checks++;
    if (first_ack != 2) begin
      n_fail++;
      $display("FAIL single_latency: ack at %0d, want 2", first_ack);
    end
    n_checks++;
    if (ack_cnt != 1) begin
      n_fail++;
      $display("FAIL single_ack_width: %0d ack cycles, want 1", ack_cnt);
    end
    n_checks++;
    if (busy_cnt != 1 + HOLD_CYCLES) begin
      n_fail++;
      $display("FAIL single_busy: busy for %0d cycles, want %0d", busy_cnt, 1 + HOLD_CYCLES);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_sb_left: %0d pending, want 0", sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    int          cyc;
    logic [3:0]  a;
    logic [15:0] d;
    exp_t        e;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) set_payload(i, 13'(13'h0010 + i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) push_exp(2'(g % N_REQ), 13'(13'h0010 + (g % N_REQ)));
    for (int g = 0; g < 5; g++) begin
      wait_grant(15, cyc, a, d);
      if (g == 4) req = 4'b0000;
      n_checks++;
      if (cyc != ((g == 0) ? 2 : HOLD_CYCLES + 2)) begin
        n_fail++;
        $display("FAIL rr_period[%0d]: %0d cycles, want %0d", g, cyc,
                 (g == 0) ? 2 : HOLD_CYCLES + 2);
      end
      if (cyc != 0) begin
        n_checks++;
        e = sb_q.pop_front();
        if ({a, d} !== {e.a, e.w}) begin
          n_fail++;
          $display("FAIL rr_word[%0d]: ack=%h wo_data=%h, want ack=%h wo_data=%h",
                   g, a, d, e.a, e.w);
        end
      end
    end
    idle_cycles(HOLD_CYCLES + 3);
  endtask

  task automatic test_freeze();
    int          cyc;
    logic [3:0]  a;
    logic [15:0] d;
    exp_t        e;
    freeze = 1'b1;
    set_payload(0, 13'h0123);
    req = 4'b0001;
    // The last update before the freeze was ID 0 with seq=1 and payload 0x10.
    for (int i = 0; i < 20; i++) begin
      @(negedge ti_clk);
      n_checks++;
      if ({ack, busy, wo_data} !== {4'b0000, 1'b0, 16'h8010}) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: ack=%h busy=%b wo_data=%h, want 0/0/8010",
                 i, ack, busy, wo_data);
      end
    end
    freeze = 1'b0;
    push_exp(2'd0, 13'h0123);
    wait_grant(6, cyc, a, d);
    req = 4'b0000;
    n_checks++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL freeze_release_latency: %0d, want 2", cyc);
    end
    if (cyc != 0) begin
      n_checks++;
      e = sb_q.pop_front();
      if ({a, d} !== {e.a, e.w}) begin
        n_fail++;
        $display("FAIL freeze_word: ack=%h wo_data=%h, want ack=%h wo_data=%h",
                 a, d, e.a, e.w);
      end
    end
    idle_cycles(HOLD_CYCLES + 3);
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [3:0]  a;
    logic [15:0] d;
    exp_t        e;
    set_payload(3, 13'h1FFF);
    req = 4'b1000;
    push_exp(2'd3, 13'h1FFF);
    push_exp(2'd3, 13'h1FFF);
    for (int g = 0; g < 2; g++) begin
      wait_grant(15, cyc, a, d);
      if (g == 1) req = 4'b0000;
      n_checks++;
      if (cyc != ((g == 0) ? 2 : HOLD_CYCLES + 2)) begin
        n_fail++;
        $display("FAIL b2b_period[%0d]: %0d, want %0d", g, cyc,
                 (g == 0) ? 2 : HOLD_CYCLES + 2);
      end
      if (cyc != 0) begin
        n_checks++;
        e = sb_q.pop_front();
        if ({a, d} !== {e.a, e.w}) begin
          n_fail++;
          $display("FAIL b2b_word[%0d]: ack=%h wo_data=%h, want ack=%h wo_data=%h",
                   g, a, d, e.a, e.w);
        end
      end
    end
    idle_cycles(HOLD_CYCLES + 3);
  endtask

  task automatic test_reset_mid_hold();
    int          cyc;
    logic [3:0]  a;
    logic [15:0] d;
    exp_t        e;
    set_payload(1, 13'h0555);
    set_payload(2, 13'h0AAA);
    req = 4'b0110;
    push_exp(2'd1, 13'h0555);
    wait_grant(6, cyc, a, d);
    n_checks++;
    if (cyc == 0) begin
      n_fail++;
      $display("FAIL mid_hold_grant: no ack, want ack=0010");
    end else begin
      e = sb_q.pop_front();
      if ({a, d} !== {e.a, e.w}) begin
        n_fail++;
        $display("FAIL mid_hold_grant: ack=%h wo_data=%h, want ack=%h wo_data=%h",
                 a, d, e.a, e.w);
      end
    end
    idle_cycles(3);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_hold_busy: busy=%b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ack, wo_data, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset: ack=%h wo_data=%h busy=%b, want 0", ack, wo_data, busy);
    end
    repeat (2) @(negedge ti_clk);
    n_checks++;
    if ({ack, wo_data, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_held: ack=%h wo_data=%h busy=%b, want 0", ack, wo_data, busy);
    end
    rst_n = 1'b1;
    seq_model = 1'b0;
    // The pointer is back at N_REQ-1, so requester 1 wins rather than 2.
    push_exp(2'd1, 13'h0555);
    wait_grant(6, cyc, a, d);
    req = 4'b0000;
    n_checks++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL post_reset_latency: %0d, want 2", cyc);
    end
    if (cyc != 0) begin
      n_checks++;
      e = sb_q.pop_front();
      if ({a, d} !== {e.a, e.w}) begin
        n_fail++;
        $display("FAIL post_reset_word: ack=%h wo_data=%h, want ack=%h wo_data=%h",
                 a, d, e.a, e.w);
      end
    end
    idle_cycles(HOLD_CYCLES + 3);
  endtask

`ifdef WOARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    int          cyc;
    logic [3:0]  a;
    logic [15:0] d;
    apply_reset();
    req = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      wait_grant(15, cyc, a, d);
      if (g == 4) req = 4'b0000;
    end
    idle_cycles(HOLD_CYCLES + 3);
    n_checks++;
    if (wo_stat !== 16'd5) begin
      n_fail++;
      $display("FAIL stat_count: wo_stat=%0d, want 5", wo_stat);
    end
    freeze = 1'b1;
    @(negedge ti_clk);
    n_checks++;
    if (wo_stat !== 16'd0) begin
      n_fail++;
      $display("FAIL stat_clear: wo_stat=%0d, want 0", wo_stat);
    end
    freeze = 1'b0;
    idle_cycles(2);
  endtask
`else
  task automatic test_grant_cnt();
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 35; i++) begin
      @(negedge ti_clk);
      n_checks++;
      if (wo_stat !== 16'h0000) begin
        n_fail++;
        $display("FAIL stat_tied[%0d]: wo_stat=%h, want 0000", i, wo_stat);
      end
    end
    req = 4'b0000;
    idle_cycles(HOLD_CYCLES + 3);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_freeze();
    test_back_to_back();
    test_reset_mid_hold();
    test_grant_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wireout_rr_arbiter.md
Name: wireout_rr_arbiter

Overview:
- Shares one host-visible 16-bit Wire Out word between N_REQ internal requesters on the ti_clk domain.
- Uses round-robin arbitration. Each grant latches the winner's payload, tags it with the source ID and a sequence toggle bit, then holds the word stable for HOLD_CYCLES so host polling reads a coherent value.
- Sits between fabric producers and a single okWireOut endpoint. An okWireIn bit drives freeze for multi-word host reads.

Parameters:
- N_REQ, 4, number of requesters; must be 4, since ID_W is fixed at 2.
- DATA_W, 13, payload bits per requester. DATA_W + 2 + 1 must equal 16.
- HOLD_CYCLES, 8, minimum cycles wo_data stays stable after an update; legal range 1..255.

Ports:
- ti_clk  in  1  host interface clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request, level
- req_data  in  N_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W]
- freeze  in  1  host hold-off (from wire-in); blocks new grants
- ack  out  N_REQ  one-cycle grant acknowledge, one-hot or zero
- wo_data  out  16  {seq, id[1:0], payload[12:0]}, to okWireOut ep_datain
- busy  out  1  high whenever state is not IDLE
- wo_stat  out  16  statistics word (see Optional Feature)

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, ack=0, wo_data=16'h0000, busy=0, wo_stat=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority. Hold counter=0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE:
  - If freeze=0 and |req, select the first requester with req set, scanning (last+1) mod N_REQ upward with wrap. Register win and go to GRANT.
  - If freeze=1 or no req, stay in IDLE.
  - Requests present while freeze=1 are not lost; they are evaluated on the first cycle with freeze=0.
- GRANT (exactly 1 cycle). On the clock edge leaving GRANT:
  - wo_data <= {~wo_data[15], win, req_data[win]}.
  - ack[win] <= 1 for exactly one cycle.
  - last <= win; counter <= HOLD_CYCLES-1; go to HOLD.
- HOLD:
  - wo_data frozen. Counter decrements each cycle; when it reaches 0, go to IDLE.
  - The earliest next GRANT is therefore HOLD_CYCLES+1 cycles after the previous update.
- Latency:
  - req seen in IDLE at cycle t → GRANT at t+1 → ack and the new wo_data visible at t+2.
  - Update-to-update minimum period is HOLD_CYCLES+2 cycles.
- Requester contract:
  - Hold req and req_data stable until ack is seen.
  - Deasserting req before ack withdraws the request. A withdrawal during GRANT is ignored, because the payload is already selected: capture still occurs and ack still fires.
  - Keeping req high after ack requests another transfer.
- Fairness: with all requests continuously high, grant order is 0,1,2,3,0,…; no requester waits more than N_REQ grants.
- Sequence bit wo_data[15] toggles on every update. The host detects a new sample by comparing it with its previous read, including back-to-back updates from the same ID with identical payload.
- freeze asserted during GRANT or HOLD has no effect on the transfer in progress; it only blocks the next IDLE→GRANT.
- Reset mid-HOLD: everything returns to reset values immediately; no ack is emitted.
- busy = (state != IDLE), registered with state.
- Out-of-range HOLD_CYCLES=0 is treated as 1.

Optional Feature:
- Macro: WOARB_GRANT_CNT_EN.
- Defined:
  - wo_stat is a 16-bit counter, incremented on each GRANT→HOLD transition and saturating at 16'hFFFF.
  - It is cleared by reset, or synchronously on any cycle where freeze rises (0→1, edge detected with a registered copy of freeze).
- Undefined: wo_stat is tied to 16'h0000 and no counter or edge-detect flops are synthesized.

Test Plan:
- Reset release, then req=4'b0100 with req_data[2]=13'h0ABC held → ack=4'b0100 pulses 2 cycles later; wo_data=16'hCABC (seq=1, id=2); busy high for 1+HOLD_CYCLES=9 cycles.
- req=4'b1111 held continuously, payload_i=13'h0010+i → grants to IDs 0,1,2,3,0 at a 10-cycle period; seq bit alternates 1,0,1,0,1.
- freeze=1 with req=4'b0001 for 20 cycles → no ack, wo_data unchanged, busy=0. Drop freeze → ack[0] 2 cycles later.
- Single requester 3 with req held and constant payload 13'h1FFF → successive wo_data values 16'hFFFF then 16'h7FFF, differing only in seq.
- rst_n pulsed low during HOLD → wo_data=0 and ack=0 asynchronously. After release, the next grant goes to the lowest requesting index.
- With WOARB_GRANT_CNT_EN: 5 grants → wo_stat=5; freeze rising edge → 0; forced 70000 grants → stays 16'hFFFF. Without the macro, wo_stat=0 throughout.
